// File: rtl/parameters_pkg.sv
// Shared definitions for uart_cmd_ctrl: command codes, FSM state encoding and
// the register-file addresses that receive the ALU operands.
package parameters_pkg;

    localparam logic [7:0] CMD_RF_WR     = 8'hAA;
    localparam logic [7:0] CMD_RF_RD     = 8'hBB;
    localparam logic [7:0] CMD_ALU_OPER  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOPER = 8'hDD;

    localparam int unsigned RF_ADDR_OP_A = 32'd0;
    localparam int unsigned RF_ADDR_OP_B = 32'd1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ADDR  = 4'd1,
        ST_WR_DATA  = 4'd2,
        ST_RD_ADDR  = 4'd3,
        ST_RD_WAIT  = 4'd4,
        ST_OP_A     = 4'd5,
        ST_OP_B     = 4'd6,
        ST_ALU_FUN  = 4'd7,
        ST_ALU_WAIT = 4'd8,
        ST_TX_B0    = 4'd9,
        ST_TX_B1    = 4'd10
    } state_e;

endpackage

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: decodes RF write/read and ALU frames, drives RF/ALU strobes and
// pushes results to the TX FIFO. Define UART_CMD_CTRL_ALU_CMD_EN to build the 0xCC/0xDD ALU commands.
module uart_cmd_ctrl
    import parameters_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_Valid,
    input  logic                    FIFO_FULL,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic [DATA_WIDTH-1:0]   WrData,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    CLK_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD
);

    state_e state_r;

`ifdef UART_CMD_CTRL_ALU_CMD_EN
    logic                  alu_en_r;
    logic                  clk_en_r;
    logic [FUN_WIDTH-1:0]  alu_fun_r;
    logic [DATA_WIDTH-1:0] tx_hi_r;
    logic                  two_byte_r;

    assign ALU_EN  = alu_en_r;
    assign CLK_EN  = clk_en_r;
    assign ALU_FUN = alu_fun_r;
`else
    logic unused_alu_s;

    assign ALU_EN       = 1'b0;
    assign CLK_EN       = 1'b0;
    assign ALU_FUN      = {FUN_WIDTH{1'b0}};
    assign unused_alu_s = ^{ALU_OUT, OUT_Valid};
`endif

    // Command FSM with all strobes and data registers; strobes default low every cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= ST_IDLE;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            Address   <= {ADDR_WIDTH{1'b0}};
            WrData    <= {DATA_WIDTH{1'b0}};
            TX_P_DATA <= {DATA_WIDTH{1'b0}};
            TX_D_VLD  <= 1'b0;
`ifdef UART_CMD_CTRL_ALU_CMD_EN
            alu_en_r   <= 1'b0;
            clk_en_r   <= 1'b0;
            alu_fun_r  <= {FUN_WIDTH{1'b0}};
            tx_hi_r    <= {DATA_WIDTH{1'b0}};
            two_byte_r <= 1'b0;
`endif
        end else begin
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            TX_D_VLD <= 1'b0;
`ifdef UART_CMD_CTRL_ALU_CMD_EN
            alu_en_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            DATA_WIDTH'(CMD_RF_WR): state_r <= ST_WR_ADDR;
                            DATA_WIDTH'(CMD_RF_RD): state_r <= ST_RD_ADDR;
`ifdef UART_CMD_CTRL_ALU_CMD_EN
                            DATA_WIDTH'(CMD_ALU_OPER): begin
                                state_r  <= ST_OP_A;
                                clk_en_r <= 1'b1;
                            end
                            DATA_WIDTH'(CMD_ALU_NOPER): begin
                                state_r  <= ST_ALU_FUN;
                                clk_en_r <= 1'b1;
                            end
`endif
                            default: state_r <= ST_IDLE;
                        endcase
                    end
                end
                ST_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state_r <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (RX_D_VLD) begin
                        WrData  <= RX_P_DATA;
                        WrEn    <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        RdEn    <= 1'b1;
                        state_r <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (RdData_Valid) begin
                        TX_P_DATA <= RdData;
`ifdef UART_CMD_CTRL_ALU_CMD_EN
                        two_byte_r <= 1'b0;
`endif
                        state_r <= ST_TX_B0;
                    end
                end
`ifdef UART_CMD_CTRL_ALU_CMD_EN
                ST_OP_A: begin
                    if (RX_D_VLD) begin
                        Address <= ADDR_WIDTH'(RF_ADDR_OP_A);
                        WrData  <= RX_P_DATA;
                        WrEn    <= 1'b1;
                        state_r <= ST_OP_B;
                    end
                end
                ST_OP_B: begin
                    if (RX_D_VLD) begin
                        Address <= ADDR_WIDTH'(RF_ADDR_OP_B);
                        WrData  <= RX_P_DATA;
                        WrEn    <= 1'b1;
                        state_r <= ST_ALU_FUN;
                    end
                end
                ST_ALU_FUN: begin
                    if (RX_D_VLD) begin
                        alu_fun_r <= RX_P_DATA[FUN_WIDTH-1:0];
                        alu_en_r  <= 1'b1;
                        state_r   <= ST_ALU_WAIT;
                    end
                end
                ST_ALU_WAIT: begin
                    if (OUT_Valid) begin
                        TX_P_DATA  <= ALU_OUT[DATA_WIDTH-1:0];
                        tx_hi_r    <= ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                        two_byte_r <= 1'b1;
                        clk_en_r   <= 1'b0;
                        state_r    <= ST_TX_B0;
                    end
                end
                // High byte is loaded on entry so it is stable while the FIFO stays full.
                ST_TX_B1: begin
                    TX_P_DATA <= tx_hi_r;
                    if (!FIFO_FULL) begin
                        TX_D_VLD <= 1'b1;
                        state_r  <= ST_IDLE;
                    end
                end
`endif
                ST_TX_B0: begin
                    if (!FIFO_FULL) begin
                        TX_D_VLD <= 1'b1;
`ifdef UART_CMD_CTRL_ALU_CMD_EN
                        state_r <= two_byte_r ? ST_TX_B1 : ST_IDLE;
`else
                        state_r <= ST_IDLE;
`endif
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed vector table, reset corner case and
// randomized command frames checked against a byte-stream reference model.
module tb_uart_cmd_ctrl;

    localparam logic [7:0] C_WR  = 8'hAA;
    localparam logic [7:0] C_RD  = 8'hBB;
    localparam logic [7:0] C_ALU = 8'hCC;
    localparam logic [7:0] C_ALN = 8'hDD;
`ifdef UART_CMD_CTRL_ALU_CMD_EN
    localparam bit ALU_BUILD = 1'b1;
`else
    localparam bit ALU_BUILD = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = 8'h00;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  RdData = 8'h00;
    logic        RdData_Valid = 1'b0;
    logic [15:0] ALU_OUT = 16'h0000;
    logic        OUT_Valid = 1'b0;
    logic        FIFO_FULL = 1'b0;
    logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD;
    logic [3:0]  Address;
    logic [7:0]  WrData, TX_P_DATA;
    logic [3:0]  ALU_FUN;

    uart_cmd_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_Valid(RdData_Valid),
        .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
        .FIFO_FULL(FIFO_FULL),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0][7:0]  b;
        int               n;
        logic [7:0]       rd;
        logic [15:0]      alu;
        int               full_hold;
        int               nev;
        logic [4:0][31:0] ev;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] obs[$];
    logic [31:0] exp_q[$];
    int          passed = 0;
    int          total = 0;
    int          onehot_viol = 0;
    int          full_viol = 0;
    logic        full_prev = 1'b0;

    // Event word: kind 1=RF write, 2=RF read, 3=ALU start, 4=TX push.
    function automatic logic [31:0] ev(input logic [7:0] kind, input logic [7:0] a, input logic [15:0] d);
        return {kind, a, d};
    endfunction

    function automatic logic [3:0][7:0] pk(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    // Observe every strobe on the opposite clock edge.
    always @(negedge CLK) begin
        if (WrEn)     obs.push_back(ev(8'd1, {4'h0, Address}, {8'h00, WrData}));
        if (RdEn)     obs.push_back(ev(8'd2, {4'h0, Address}, 16'h0000));
        if (ALU_EN)   obs.push_back(ev(8'd3, {4'h0, ALU_FUN}, {15'h0000, CLK_EN}));
        if (TX_D_VLD) obs.push_back(ev(8'd4, 8'h00, {8'h00, TX_P_DATA}));
        if ((int'(WrEn) + int'(RdEn) + int'(ALU_EN) + int'(TX_D_VLD)) > 1) onehot_viol++;
        if (TX_D_VLD && full_prev) full_viol++;
        full_prev = FIFO_FULL;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) $display("FAIL %s: got %h, expected %h", name, act, expv);
        else passed++;
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        step();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
        repeat ($urandom_range(0, 2)) step();
    endtask

    // Reference model: interpret a command frame as a byte stream and list the expected strobes.
    function automatic void model(input logic [3:0][7:0] b, input int n, input logic [7:0] rd, input logic [15:0] alu);
        int i = 0;
        exp_q.delete();
        while (i < n) begin
            if (b[i] == C_WR && i + 2 < n) begin
                exp_q.push_back(ev(8'd1, b[i+1] & 8'h0F, {8'h00, b[i+2]}));
                i += 3;
            end else if (b[i] == C_RD && i + 1 < n) begin
                exp_q.push_back(ev(8'd2, b[i+1] & 8'h0F, 16'h0000));
                exp_q.push_back(ev(8'd4, 8'h00, {8'h00, rd}));
                i += 2;
            end else if (ALU_BUILD && b[i] == C_ALU && i + 3 < n) begin
                exp_q.push_back(ev(8'd1, 8'h00, {8'h00, b[i+1]}));
                exp_q.push_back(ev(8'd1, 8'h01, {8'h00, b[i+2]}));
                exp_q.push_back(ev(8'd3, b[i+3] & 8'h0F, 16'h0001));
                exp_q.push_back(ev(8'd4, 8'h00, {8'h00, alu[7:0]}));
                exp_q.push_back(ev(8'd4, 8'h00, {8'h00, alu[15:8]}));
                i += 4;
            end else if (ALU_BUILD && b[i] == C_ALN && i + 1 < n) begin
                exp_q.push_back(ev(8'd3, b[i+1] & 8'h0F, 16'h0001));
                exp_q.push_back(ev(8'd4, 8'h00, {8'h00, alu[7:0]}));
                exp_q.push_back(ev(8'd4, 8'h00, {8'h00, alu[15:8]}));
                i += 2;
            end else begin
                i += 1;
            end
        end
    endfunction

    // Drive one frame plus responses, then compare observed strobes with exp_q.
    task automatic run_vec(input string tag, input logic [3:0][7:0] b, input int n, input logic [7:0] rd,
                           input logic [15:0] alu, input int full_hold, input bit full_rand);
        bit wait_rsp;
        obs.delete();
        FIFO_FULL = (full_hold > 0);
        for (int i = 0; i < n; i++) send_byte(b[i]);
        wait_rsp = (b[0] == C_RD) || (ALU_BUILD && (b[0] == C_ALU || b[0] == C_ALN));
        if (wait_rsp) begin
            RX_P_DATA = 8'($urandom);
            RX_D_VLD  = 1'b1;
            step();
            RX_D_VLD = 1'b0;
            RdData = rd;
            RdData_Valid = 1'b1;
            step();
            RdData_Valid = 1'b0;
            RdData = 8'($urandom);
            ALU_OUT = alu;
            OUT_Valid = 1'b1;
            step();
            OUT_Valid = 1'b0;
            ALU_OUT = 16'($urandom);
        end
        for (int k = 0; k < full_hold; k++) step();
        for (int k = 0; k < 200 && obs.size() < exp_q.size(); k++) begin
            FIFO_FULL = full_rand ? ((k < 40) && ($urandom_range(0, 1) == 1)) : 1'b0;
            step();
        end
        FIFO_FULL = 1'b0;
        repeat (4) step();
        chk({tag, "_count"}, 32'(obs.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_ev%0d", tag, i), (i < obs.size()) ? obs[i] : 32'hDEAD_DEAD, exp_q[i]);
        chk({tag, "_idle"}, 32'({WrEn, RdEn, ALU_EN, TX_D_VLD, CLK_EN}), 32'h0);
    endtask

    task automatic add(input logic [3:0][7:0] b, input int n, input logic [7:0] rd, input logic [15:0] alu,
                       input int fh, input int nev, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] e4);
        vec_t v;
        v.b = b; v.n = n; v.rd = rd; v.alu = alu; v.full_hold = fh; v.nev = nev;
        v.ev = {e4, e3, e2, e1, e0};
        tbl.push_back(v);
    endtask

    initial begin
        vec_t v;
        logic [3:0][7:0] rb;
        int rn;
        logic [7:0] rrd;
        logic [15:0] ralu;

        add(pk(C_WR, 8'h05, 8'h3C, 8'h00), 3, 8'h00, 16'h0000, 0, 1,
            ev(8'd1, 8'h05, 16'h003C), 32'h0, 32'h0, 32'h0, 32'h0);
        add(pk(C_RD, 8'h02, 8'h00, 8'h00), 2, 8'h7E, 16'h0000, 0, 2,
            ev(8'd2, 8'h02, 16'h0000), ev(8'd4, 8'h00, 16'h007E), 32'h0, 32'h0, 32'h0);
        add(pk(8'h55, 8'h00, 8'h00, 8'h00), 1, 8'h00, 16'h0000, 0, 0,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        add(pk(C_WR, 8'hF5, 8'hFF, 8'h00), 3, 8'h00, 16'h0000, 0, 1,
            ev(8'd1, 8'h05, 16'h00FF), 32'h0, 32'h0, 32'h0, 32'h0);
        add(pk(C_RD, 8'h0A, 8'h00, 8'h00), 2, 8'h81, 16'h0000, 3, 2,
            ev(8'd2, 8'h0A, 16'h0000), ev(8'd4, 8'h00, 16'h0081), 32'h0, 32'h0, 32'h0);
`ifdef UART_CMD_CTRL_ALU_CMD_EN
        add(pk(C_ALU, 8'h10, 8'h20, 8'h00), 4, 8'h00, 16'h0030, 0, 5,
            ev(8'd1, 8'h00, 16'h0010), ev(8'd1, 8'h01, 16'h0020), ev(8'd3, 8'h00, 16'h0001),
            ev(8'd4, 8'h00, 16'h0030), ev(8'd4, 8'h00, 16'h0000));
        add(pk(C_ALN, 8'h01, 8'h00, 8'h00), 2, 8'h00, 16'hABCD, 5, 3,
            ev(8'd3, 8'h01, 16'h0001), ev(8'd4, 8'h00, 16'h00CD), ev(8'd4, 8'h00, 16'h00AB),
            32'h0, 32'h0);
`else
        add(pk(C_ALU, 8'h10, 8'h00, 8'h00), 2, 8'h00, 16'h0000, 0, 0,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        add(pk(C_WR, 8'h01, 8'hFF, 8'h00), 3, 8'h00, 16'h0000, 0, 1,
            ev(8'd1, 8'h01, 16'h00FF), 32'h0, 32'h0, 32'h0, 32'h0);
        add(pk(C_ALN, 8'h03, 8'h00, 8'h00), 2, 8'h00, 16'h0000, 0, 0,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
`endif

        // Reset state
        repeat (3) step();
        chk("reset_outputs", 32'({WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, Address, WrData, ALU_FUN, TX_P_DATA}), 32'h0);
        RST = 1'b1;
        repeat (2) step();
        chk("post_reset_outputs", 32'({WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, Address, WrData, ALU_FUN, TX_P_DATA}), 32'h0);

        // Directed table
        for (int t = 0; t < tbl.size(); t++) begin
            v = tbl[t];
            exp_q.delete();
            for (int j = 0; j < v.nev; j++) exp_q.push_back(v.ev[j]);
            run_vec($sformatf("vec%0d", t), v.b, v.n, v.rd, v.alu, v.full_hold, 1'b0);
        end

        // Reset while waiting for read data abandons the read
        obs.delete();
        send_byte(C_RD);
        send_byte(8'h03);
        step();
        RST = 1'b0;
        step();
        chk("rst_in_rd_wait_outputs", 32'({WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, Address, WrData, ALU_FUN, TX_P_DATA}), 32'h0);
        RST = 1'b1;
        step();
        RdData = 8'h99;
        RdData_Valid = 1'b1;
        step();
        RdData_Valid = 1'b0;
        repeat (10) step();
        chk("rst_in_rd_wait_count", 32'(obs.size()), 32'd1);
        chk("rst_in_rd_wait_rd", (obs.size() > 0) ? obs[0] : 32'hDEAD_DEAD, ev(8'd2, 8'h03, 16'h0000));
        chk("rst_in_rd_wait_idle", 32'({WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, Address, WrData, ALU_FUN, TX_P_DATA}), 32'h0);
        exp_q.delete();
        exp_q.push_back(ev(8'd1, 8'h07, 16'h005A));
        run_vec("after_rst_wr", pk(C_WR, 8'h07, 8'h5A, 8'h00), 3, 8'h00, 16'h0000, 0, 1'b0);

        // Randomized frames against the reference model
        for (int r = 0; r < 30; r++) begin
            rb = pk(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            rrd = 8'($urandom);
            ralu = 16'($urandom);
            case ($urandom_range(0, 4))
                0: begin rb[0] = C_WR; rn = 3; end
                1: begin rb[0] = C_RD; rn = 2; end
                2: begin rb[0] = 8'($urandom_range(0, 159)); rn = 1; end
                3: begin rb[0] = C_ALU; rn = ALU_BUILD ? 4 : 1; end
                default: begin rb[0] = C_ALN; rn = ALU_BUILD ? 2 : 1; end
            endcase
            model(rb, rn, rrd, ralu);
            run_vec($sformatf("rnd%0d", r), rb, rn, rrd, ralu, 0, 1'b1);
        end

        chk("strobe_onehot_violations", 32'(onehot_viol), 32'h0);
        chk("push_while_full_violations", 32'(full_viol), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
